// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared comparator codes, funct3 values and FSM states for branch_ctrl
package branch_pkg;

  localparam logic [3:0] CMP_NONE = 4'b0000;
  localparam logic [3:0] CMP_BEQ  = 4'b1100;
  localparam logic [3:0] CMP_BNE  = 4'b1101;
  localparam logic [3:0] CMP_BLT  = 4'b0111;
  localparam logic [3:0] CMP_BGE  = 4'b1011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESOLVE,
    FLUSH
  } state_e;

endpackage

// File: rtl/branch_decode.sv
// rtl/branch_decode.sv - funct3 to comparator control code; unsupported encodings map to CMP_NONE
module branch_decode
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  output logic [3:0] cmp_ctl,
  output logic       illegal
);

  always_comb begin
    cmp_ctl = CMP_NONE;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cmp_ctl = CMP_BEQ;
      F3_BNE:  cmp_ctl = CMP_BNE;
      F3_BLT:  cmp_ctl = CMP_BLT;
      F3_BGE:  cmp_ctl = CMP_BGE;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolution FSM: stall, comparator drive, PC redirect and flush
// Statistics counters are built only when BRANCH_CTRL_STATS_EN is defined.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic [2:0]       br_funct3,
  input  logic [XLEN-1:0]  br_target,
  input  logic             opnd_busy,
  input  logic             cmp_out,
  output logic [3:0]       cmp_ctl,
  output logic             stall,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic             flush,
  output logic             br_illegal,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_stall_cyc
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        code_q, code_d;
  logic              ill_q, ill_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic [3:0]        ctl_q, ctl_d;
  logic              bri_q, bri_d;
  logic [3:0]        dec_ctl;
  logic              dec_ill;
  logic              taken;

  branch_decode u_decode (
    .funct3  (br_funct3),
    .cmp_ctl (dec_ctl),
    .illegal (dec_ill)
  );

  // Illegal branches never redirect, even if the comparator reports true.
  assign taken = (state_q == RESOLVE) & cmp_out & ~bri_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    ill_d   = ill_q;
    tgt_d   = tgt_q;
    ctl_d   = CMP_NONE;
    bri_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (br_valid) begin
          code_d = dec_ctl;
          ill_d  = dec_ill;
          tgt_d  = br_target;
          if (opnd_busy) begin
            state_d = WAIT;
          end else begin
            state_d = RESOLVE;
            ctl_d   = dec_ctl;
            bri_d   = dec_ill;
          end
        end
      end
      WAIT: begin
        // The branch was captured on entry, so a dropped br_valid cannot lose it.
        if (!opnd_busy) begin
          state_d = RESOLVE;
          ctl_d   = code_q;
          bri_d   = ill_q;
        end
      end
      RESOLVE: begin
        state_d = IDLE;
        if (taken && FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      code_q  <= CMP_NONE;
      ill_q   <= 1'b0;
      tgt_q   <= '0;
      ctl_q   <= CMP_NONE;
      bri_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      ill_q   <= ill_d;
      tgt_q   <= tgt_d;
      ctl_q   <= ctl_d;
      bri_q   <= bri_d;
    end
  end

  assign cmp_ctl    = ctl_q;
  assign br_illegal = bri_q;
  assign pc_target  = tgt_q;
  assign pc_sel     = taken;
  assign flush      = taken | (state_q == FLUSH);
  assign stall      = (state_q != IDLE) | br_valid;

`ifdef BRANCH_CTRL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] st_br_q, st_br_d;
  logic [CNT_W-1:0] st_tk_q, st_tk_d;
  logic [CNT_W-1:0] st_sc_q, st_sc_d;

  always_comb begin
    st_br_d = st_br_q;
    st_tk_d = st_tk_q;
    st_sc_d = st_sc_q;
    if (state_q == RESOLVE) st_br_d = st_br_q + CNT_ONE;
    if (taken)              st_tk_d = st_tk_q + CNT_ONE;
    if (stall)              st_sc_d = st_sc_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_br_q <= '0;
      st_tk_q <= '0;
      st_sc_q <= '0;
    end else begin
      st_br_q <= st_br_d;
      st_tk_q <= st_tk_d;
      st_sc_q <= st_sc_d;
    end
  end

  assign stat_branches  = st_br_q;
  assign stat_taken     = st_tk_q;
  assign stat_stall_cyc = st_sc_q;
`else
  assign stat_branches  = '0;
  assign stat_taken     = '0;
  assign stat_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed and random branch sequences checked against a timeline model
module tb_branch_ctrl;

  localparam int XLEN  = 32;
  localparam int FC    = 2;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             br_valid;
  logic [2:0]       br_funct3;
  logic [XLEN-1:0]  br_target;
  logic             opnd_busy;
  logic             cmp_out;
  logic [3:0]       cmp_ctl;
  logic             stall;
  logic             pc_sel;
  logic [XLEN-1:0]  pc_target;
  logic             flush;
  logic             br_illegal;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_taken;
  logic [CNT_W-1:0] stat_stall_cyc;

  int checks   = 0;
  int failures = 0;
  int m_br     = 0;
  int m_tk     = 0;
  int m_st     = 0;

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .br_valid       (br_valid),
    .br_funct3      (br_funct3),
    .br_target      (br_target),
    .opnd_busy      (opnd_busy),
    .cmp_out        (cmp_out),
    .cmp_ctl        (cmp_ctl),
    .stall          (stall),
    .pc_sel         (pc_sel),
    .pc_target      (pc_target),
    .flush          (flush),
    .br_illegal     (br_illegal),
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken),
    .stat_stall_cyc (stat_stall_cyc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {legal, comparator code} straight from the branch table
  function automatic logic [4:0] ref_code(input logic [2:0] f3);
    case (f3)
      3'b000:  return {1'b1, 4'b1100};
      3'b001:  return {1'b1, 4'b1101};
      3'b100:  return {1'b1, 4'b0111};
      3'b101:  return {1'b1, 4'b1011};
      default: return {1'b0, 4'b0000};
    endcase
  endfunction

  task automatic check_stats();
    logic [CNT_W-1:0] e_br, e_tk, e_st;
`ifdef BRANCH_CTRL_STATS_EN
    e_br = CNT_W'(m_br);
    e_tk = CNT_W'(m_tk);
    e_st = CNT_W'(m_st);
`else
    e_br = '0;
    e_tk = '0;
    e_st = '0;
`endif
    chk("stat_branches", stat_branches, e_br);
    chk("stat_taken", stat_taken, e_tk);
    chk("stat_stall_cyc", stat_stall_cyc, e_st);
  endtask

  task automatic idle_cycles(input int n);
    br_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      opnd_busy = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_stall", stall, 1'b0);
      chk("idle_flush", flush, 1'b0);
      @(posedge clk); #1;
    end
    opnd_busy = 1'b0;
  endtask

  // Entered 1 time unit after a rising edge; returns at the same phase.
  task automatic run_branch(input logic [2:0] f3, input logic [XLEN-1:0] tgt,
                            input int busy, input logic cv, input bit abort);
    logic [4:0] rc;
    logic       legal;
    logic [3:0] ectl;
    logic       tk;
    int         r;
    rc    = ref_code(f3);
    legal = rc[4];
    ectl  = rc[3:0];
    tk    = cv & legal;
    r     = busy + 1;
    br_valid  = 1'b1;
    br_funct3 = f3;
    br_target = tgt;
    cmp_out   = 1'b0;
    for (int c = 0; c < r; c++) begin
      opnd_busy = (c < busy);
      @(negedge clk);
      chk("pre_stall", stall, 1'b1);
      chk("pre_cmp_ctl", cmp_ctl, 4'b0000);
      chk("pre_flush", flush, 1'b0);
      chk("pre_pc_sel", pc_sel, 1'b0);
      m_st++;
      @(posedge clk); #1;
    end
    opnd_busy = 1'b0;
    cmp_out   = cv;
    @(negedge clk);
    chk("res_cmp_ctl", cmp_ctl, ectl);
    chk("res_illegal", br_illegal, !legal);
    chk("res_pc_sel", pc_sel, tk);
    chk("res_flush", flush, tk);
    chk("res_stall", stall, 1'b1);
    if (tk) chk("res_pc_target", pc_target, tgt);
    m_st++;
    m_br++;
    if (tk) m_tk++;
    @(posedge clk); #1;
    cmp_out = 1'b0;
    if (tk) begin
      for (int c = 1; c < FC; c++) begin
        @(negedge clk);
        chk("fl_flush", flush, 1'b1);
        chk("fl_pc_sel", pc_sel, 1'b0);
        chk("fl_cmp_ctl", cmp_ctl, 4'b0000);
        chk("fl_illegal", br_illegal, 1'b0);
        chk("fl_stall", stall, 1'b1);
        m_st++;
        if (abort) begin
          #1;
          rst      = 1'b1;
          br_valid = 1'b0;
          #1;
          chk("rst_flush", flush, 1'b0);
          chk("rst_stall", stall, 1'b0);
          chk("rst_pc_sel", pc_sel, 1'b0);
          chk("rst_pc_target", pc_target, {XLEN{1'b0}});
          @(posedge clk); #1;
          rst  = 1'b0;
          m_br = 0;
          m_tk = 0;
          m_st = 0;
          return;
        end
        @(posedge clk); #1;
      end
    end
    br_valid = 1'b0;
    @(negedge clk);
    chk("post_stall", stall, 1'b0);
    chk("post_flush", flush, 1'b0);
    chk("post_cmp_ctl", cmp_ctl, 4'b0000);
    chk("post_illegal", br_illegal, 1'b0);
    chk("post_pc_sel", pc_sel, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b1;
    br_valid  = 1'b0;
    br_funct3 = 3'b000;
    br_target = '0;
    opnd_busy = 1'b0;
    cmp_out   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", stall, 1'b0);
    chk("reset_pc_sel", pc_sel, 1'b0);
    chk("reset_flush", flush, 1'b0);
    chk("reset_cmp_ctl", cmp_ctl, 4'b0000);
    chk("reset_illegal", br_illegal, 1'b0);
    chk("reset_pc_target", pc_target, {XLEN{1'b0}});
    check_stats();
    @(posedge clk); #1;
    rst = 1'b0;

    run_branch(3'b000, 32'h0000_0040, 0, 1'b1, 1'b0);
    run_branch(3'b001, 32'h0000_1000, 0, 1'b0, 1'b0);
    run_branch(3'b100, 32'h0000_2468, 3, 1'b1, 1'b0);
    run_branch(3'b110, 32'h0000_3000, 0, 1'b1, 1'b0);
    run_branch(3'b101, 32'hFFFF_FFFC, 1, 1'b1, 1'b0);
    check_stats();

    run_branch(3'b000, 32'h0000_0080, 0, 1'b1, 1'b1);
    check_stats();
    run_branch(3'b000, 32'h0000_00C0, 0, 1'b1, 1'b0);
    run_branch(3'b001, 32'h0000_0100, 2, 1'b1, 1'b0);
    run_branch(3'b100, 32'h0000_0140, 0, 1'b0, 1'b0);
    run_branch(3'b111, 32'h0000_0180, 1, 1'b0, 1'b0);
    check_stats();

    for (int i = 0; i < 40; i++) begin
      run_branch(3'($urandom_range(0, 7)), XLEN'($urandom),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      idle_cycles(int'($urandom_range(0, 2)));
    end
    check_stats();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch-resolution controller for the pipelined RV32 core. Accepts one B-type branch at a time from decode, stalls it until operands are ready, and drives the 4-bit control code into the existing branch comparator for exactly one cycle. It samples the comparator result, then issues the PC redirect and a fixed-length pipeline flush on a taken branch. It sits between the decode stage, the hazard unit and the branch comparator.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- FLUSH_CYCLES, 2, flush length after a taken branch; legal range 1..7
- CNT_W, 32, width of the statistics counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- br_valid  in  1  decode holds a branch; held stable while stall=1
- br_funct3  in  3  funct3 of the branch
- br_target  in  XLEN  precomputed branch target PC
- opnd_busy  in  1  rs1/rs2 not yet forwardable (load-use hazard)
- cmp_out  in  1  comparator result (BranchOut)
- cmp_ctl  out  4  comparator control code
- stall  out  1  freeze IF/ID
- pc_sel  out  1  one-cycle pulse: select pc_target as next PC
- pc_target  out  XLEN  redirect address, valid while pc_sel=1
- flush  out  1  kill younger instructions in IF/ID
- br_illegal  out  1  one-cycle pulse: unsupported funct3 accepted
- stat_branches, stat_taken, stat_stall_cyc  out  CNT_W  statistics counters (see Configuration)

## Operation
- funct3 → cmp_ctl: 000 BEQ→1100; 001 BNE→1101; 100 BLT→0111; 101 BGE→1011.
- funct3 010/011/110/111 are unsupported. They are accepted, resolve as not-taken, and pulse br_illegal in the RESOLVE cycle.
- cmp_ctl is 0000 in every state except RESOLVE, so the comparator output is 0.
- IDLE:
  - br_valid & opnd_busy → WAIT.
  - br_valid & !opnd_busy → accept: latch the code and br_target, go to RESOLVE.
  - !br_valid → stay.
- WAIT: when opnd_busy falls, accept and go to RESOLVE.
- RESOLVE:
  - Drive the latched cmp_ctl and sample cmp_out.
  - Taken: pulse pc_sel, drive pc_target, assert flush, load cnt=FLUSH_CYCLES-1, go to FLUSH. If FLUSH_CYCLES=1, go straight to IDLE.
  - Not taken: go to IDLE.
- FLUSH: flush=1 each cycle; cnt decrements; when cnt=0, go to IDLE.
- stall = (state≠IDLE) | (IDLE & br_valid). Decode must not advance the branch until stall is low.
- The branch leaves decode in the cycle after RESOLVE or after the last FLUSH cycle.

## Timing
- Reset: state=IDLE, cnt=0, pc_target=0, all outputs 0, statistics counters 0.
- Latency with no hazard:
  - accept in cycle 0
  - RESOLVE in cycle 1
  - not taken: back in IDLE in cycle 2
  - taken: flush high in cycles 1..FLUSH_CYCLES, IDLE in cycle FLUSH_CYCLES+1
- Each cycle spent in WAIT adds one cycle of latency.
- pc_target, br_illegal and cmp_ctl are registered and change only on state transitions. stall is combinational from state and br_valid.
- br_valid deasserting while stall=1 is a protocol violation; the latched branch still completes.
- A new branch is not accepted until IDLE is re-entered. The minimum spacing between accepted branches is 2 cycles.
- rst mid-WAIT, RESOLVE or FLUSH aborts the operation: no pc_sel pulse, flush drops asynchronously.

## Configuration
- BRANCH_CTRL_STATS_EN defined:
  - stat_branches increments once per RESOLVE.
  - stat_taken increments once per taken RESOLVE.
  - stat_stall_cyc increments every cycle stall=1.
  - All three wrap modulo 2^CNT_W and clear on rst.
- BRANCH_CTRL_STATS_EN undefined: the counters are not built and the three stat ports are tied to 0.

## Structure
- Shared package branch_pkg:
  - cmp_ctl code constants (CMP_BLT, CMP_BGE, CMP_BEQ, CMP_BNE, CMP_NONE)
  - funct3 constants
  - state enum (IDLE, WAIT, RESOLVE, FLUSH)
- One sub-module, branch_decode: combinational funct3 → {cmp_ctl, illegal}.
- The FSM, flush counter and statistics stay in branch_ctrl.

## Test plan
- BEQ (funct3 000), cmp_out=1, target 0x0000_0040 → cmp_ctl=1100 in cycle 1; pc_sel and flush high in cycle 1; pc_target=0x40; flush high in cycles 1–2; IDLE in cycle 3.
- BNE, cmp_out=0 → cmp_ctl=1101 in cycle 1 only; no pc_sel; stall low in cycle 2.
- BLT with opnd_busy high for 3 cycles → stall high through WAIT; cmp_ctl=0111 exactly one cycle after opnd_busy falls.
- funct3 110 → br_illegal pulses for 1 cycle; cmp_ctl stays 0000; not taken.
- rst asserted during FLUSH → flush and stall drop immediately; next branch is handled normally.
- STATS_EN build: 4 branches with 2 taken → stat_branches=4, stat_taken=2; stat_stall_cyc matches the counted stall cycles.
